// File: rtl/digital_tube_scanner.sv
// Six-digit multiplexed 7-segment scanner with per-frame input snapshot.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module digital_tube_scanner #(
  parameter int SCAN_DIV = 50_000
) (
  input  logic       system_clock,
  input  logic       system_reset,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [3:0] hundred,
  input  logic [3:0] thousand,
  input  logic [3:0] ten_thousand,
  input  logic [3:0] hundred_thousand,
  input  logic [5:0] point,
  input  logic       enable,
  output logic [5:0] selection,
  output logic [7:0] segment,
  output logic       frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]   r_presc;
  logic [2:0]      r_idx;
  logic            r_first;
  logic [5:0][3:0] r_sh_dig;
  logic [5:0]      r_sh_pt;
  logic [5:0]      r_sel;
  logic [7:0]      r_seg;
  logic            r_fs;

  logic            w_tick;
  logic            w_wrap;
  logic            w_snap;
  logic [3:0]      w_dig;
  logic            w_dp;
  logic            w_lz;

  function automatic logic [7:0] seg_decode(input logic [3:0] d, input logic dp,
                                            input logic blank);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    if (blank) s = 8'hFF;
    if (dp)    s[7] = 1'b0;
    return s;
  endfunction

  // The snapshot cycle after reset holds the prescaler so every slot is SCAN_DIV long.
  assign w_tick = !r_first && (r_presc == PW'(SCAN_DIV - 1));
  assign w_wrap = w_tick && (r_idx == 3'd5);
  assign w_snap = r_first || w_wrap;

  always_comb begin
    w_dig = 4'd0;
    w_dp  = 1'b0;
    case (r_idx)
      3'd0: begin w_dig = r_sh_dig[0]; w_dp = r_sh_pt[0]; end
      3'd1: begin w_dig = r_sh_dig[1]; w_dp = r_sh_pt[1]; end
      3'd2: begin w_dig = r_sh_dig[2]; w_dp = r_sh_pt[2]; end
      3'd3: begin w_dig = r_sh_dig[3]; w_dp = r_sh_pt[3]; end
      3'd4: begin w_dig = r_sh_dig[4]; w_dp = r_sh_pt[4]; end
      3'd5: begin w_dig = r_sh_dig[5]; w_dp = r_sh_pt[5]; end
      default: begin w_dig = 4'd0; w_dp = 1'b0; end
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is blank when it and every higher shadow digit are zero.
  always_comb begin
    logic acc;
    acc  = 1'b1;
    w_lz = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      acc = acc && (r_sh_dig[k] == 4'd0);
      if (r_idx == 3'(k)) w_lz = acc;
    end
  end
`else
  assign w_lz = 1'b0;
`endif

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      r_presc  <= '0;
      r_idx    <= 3'd0;
      r_first  <= 1'b1;
      r_sh_dig <= '0;
      r_sh_pt  <= '0;
      r_sel    <= 6'b111111;
      r_seg    <= 8'hFF;
      r_fs     <= 1'b0;
    end else begin
      r_first <= 1'b0;
      r_fs    <= w_snap;
      if (!r_first) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if (w_tick) begin
        r_idx <= w_wrap ? 3'd0 : r_idx + 3'd1;
      end
      if (w_snap) begin
        r_sh_dig <= {hundred_thousand, ten_thousand, thousand, hundred, ten, one};
        r_sh_pt  <= point;
      end
      if (r_first || !enable) begin
        r_sel <= 6'b111111;
        r_seg <= 8'hFF;
      end else begin
        r_sel <= ~(6'b000001 << r_idx);
        r_seg <= seg_decode(w_dig, w_dp, w_lz);
      end
    end
  end

  assign selection   = r_sel;
  assign segment     = r_seg;
  assign frame_start = r_fs;

endmodule

// File: doc/digital_tube_scanner.md
DIGITAL_TUBE_SCANNER -- requirements
Module: digital_tube_scanner

Interface
REQ-001 Parameter: SCAN_DIV, 50_000, clocks per digit slot (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Port: system_clock  in  1  single clock; all logic on rising edge.
REQ-003 Port: system_reset  in  1  synchronous, active-high reset.
REQ-004 Port: one, ten, hundred, thousand, ten_thousand, hundred_thousand  in  4 each  BCD digits from the binary-to-BCD stage.
REQ-005 Port: point  in  6  decimal-point enable per digit; bit0 = one ... bit5 = hundred_thousand.
REQ-006 Port: enable  in  1  display on; low blanks the tube.
REQ-007 Port: selection  out  6  digit select, one-hot active-low; bit0 drives the one digit.
REQ-008 Port: segment  out  8  common-anode segments, active-low; bit7 = dp, bits6..0 = g..a.
REQ-009 Port: frame_start  out  1  one-cycle pulse when a new input snapshot is taken.

Function
REQ-010 Prescaler shall count 0..SCAN_DIV-1, wrap to 0; tick asserted in the cycle it equals SCAN_DIV-1.
REQ-011 Digit index shall be 0..5, advance by 1 on each tick, and wrap 5 -> 0.
REQ-012 The six digits and point shall be latched into shadow registers only on the tick that wraps the index 5 -> 0, and on the first clock after reset release.
REQ-013 frame_start shall pulse high for exactly one cycle in each cycle a snapshot is taken.
REQ-014 Input changes between snapshots shall not affect displayed data (no tearing within a frame).
REQ-015 selection and segment shall be registered, reflecting index and shadow data one clock after the index changes.
REQ-016 Decode (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); codes 10..15 shall output FF.
REQ-017 When the shadow point bit of the active digit is 1, segment bit7 shall be 0; all other bits per REQ-016.
REQ-018 A non-decimal code (10..15) with point set shall output 7F.
REQ-019 enable low: selection = 111111 and segment = FF from the next clock; prescaler, index, and snapshots continue running.
REQ-020 enable rising: normal output resumes on the next clock at the current index; no frame restart.
REQ-021 Digit period shall be exactly SCAN_DIV clocks; frame period exactly 6*SCAN_DIV clocks.

Reset
REQ-022 While system_reset is high at a clock edge: prescaler = 0, index = 0, shadow digits = 0, shadow point = 0, selection = 111111, segment = FF, frame_start = 0.
REQ-023 Reset asserted mid-frame shall take effect at the next edge regardless of prescaler or index state.
REQ-024 First clock after release: snapshot taken, frame_start = 1; next clock selection = 111110 showing shadow one.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: digit k (k = 1..5) shall output FF (or 7F if its point bit is set) when it and all higher shadow digits are 0; digit 0 is never blanked.
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: every digit shall be decoded per REQ-016/017 with no blanking.
REQ-027 Blanking decision shall use shadow data only and add no latency.

Verification (SCAN_DIV = 4)
REQ-028 Reset, release with hundred_thousand..one = 1,2,3,4,5,6, enable = 1 -> frame_start pulse; selection 111110/seg 82, then every 4 clocks 111101/92, 111011/99, 110111/B0, 101111/A4, 011111/F9, then 111110 again with frame_start.
REQ-029 Change inputs to 6,5,4,3,2,1 while index = 2 -> remaining digits of the frame show old values; new values appear only after the next frame_start.
REQ-030 Inputs 0,0,0,0,4,2, point = 000000 -> with LEADING_ZERO_BLANK_EN: digits 2..5 = FF, digit1 = 99, digit0 = A4; without: digits 2..5 = C0.
REQ-031 point = 000100 with hundred = 4 -> hundred slot segment = 19; other slots unchanged.
REQ-032 Drop enable for 10 clocks mid-digit -> selection 111111, segment FF after 1 clock; index sequence and frame_start timing identical to an enable-high run.
REQ-033 Assert system_reset for 1 clock at index 3 -> next clock selection 111111, segment FF; after release sequence restarts per REQ-024.
